// File: rtl/sar_logic_param.sv
// rtl/sar_logic_param.sv - parametrised successive-approximation ADC controller
//
// Sequences the bootstrap sampling switch, CDAC settle time, comparator strobe
// and per-bit decision of a BITS-wide binary-weighted SAR converter. It can run
// single-shot or back-to-back conversions. It also reports requests that arrive
// while a conversion is in progress.
//
// Parameters:
//   BITS          conversion resolution (2..16)
//   SAMPLE_CYCLES cycles s_clk stays high in SAMPLE (>=1)
//   SETTLE_CYCLES DAC settle cycles before each comparator strobe (>=1)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active high
//   cnvst        start-of-conversion request (level)
//   cont_mode    1 = restart automatically after each conversion
//   ovr_clr      clears the sticky overrun flag
//   cmp_out      comparator decision, 1 = input above DAC level (keep bit)
//   sar          last completed result, held between conversions
//   eoc          one-cycle end-of-conversion pulse
//   busy         high whenever the controller is not idle
//   overrun      sticky: a request arrived while busy in single-shot mode
//   cmp_clk      comparator strobe
//   s_clk        bootstrap sampling switch, s_clk_not its complement
//   dac_code     CDAC trial code, dac_code_not its complement

module sar_logic_param #(
    parameter int BITS          = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cnvst,
    input  logic            cont_mode,
    input  logic            ovr_clr,
    input  logic            cmp_out,
    output logic [BITS-1:0] sar,
    output logic            eoc,
    output logic            busy,
    output logic            overrun,
    output logic            cmp_clk,
    output logic            s_clk,
    output logic            s_clk_not,
    output logic [BITS-1:0] dac_code,
    output logic [BITS-1:0] dac_code_not
);

    localparam int IDX_W   = $clog2(BITS);
    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [BITS-1:0]  TRIAL_MSB   = {1'b1, {(BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAMPLE  = 3'd1,
        SETTLE  = 3'd2,
        COMPARE = 3'd3,
        DECIDE  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  bit_next;
    logic [IDX_W-1:0]  bit_dn;
    logic [BITS-1:0]   trial;
    logic [BITS-1:0]   trial_next;
    logic [BITS-1:0]   sar_q;
    logic              eoc_q;
    logic              cmp_clk_q;
    logic              busy_q;
    logic              overrun_q;

    // Flop inputs for the registered outputs, derived from the next state so
    // that each output lines up exactly with the state it describes.
    logic              eoc_d;
    logic              cmp_clk_d;
    logic              busy_d;
    logic              overrun_d;

    assign bit_dn = bit_idx - IDX_ONE;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            trial     <= '0;
            sar_q     <= '0;
            eoc_q     <= 1'b0;
            cmp_clk_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_next;
            trial     <= trial_next;
            eoc_q     <= eoc_d;
            cmp_clk_q <= cmp_clk_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            // The result only moves on the edge that enters DONE, so it stays
            // stable for the whole of the following conversion.
            if (state_next == DONE) begin
                sar_q <= trial_next;
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        trial_next = trial;

        case (state)
            IDLE: begin
                trial_next = '0;
                if (cnvst) begin
                    state_next = SAMPLE;
                    cnt_next   = SAMPLE_LOAD;
                end
            end

            SAMPLE: begin
                if (cnt == '0) begin
                    state_next = SETTLE;
                    trial_next = TRIAL_MSB;
                    bit_next   = IDX_TOP;
                    cnt_next   = SETTLE_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end

            SETTLE: begin
                if (cnt == '0) begin
                    state_next = COMPARE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end

            COMPARE: begin
                state_next = DECIDE;
            end

            DECIDE: begin
                // Comparator below the trial level: this bit overshoots.
                if (!cmp_out) begin
                    trial_next[bit_idx] = 1'b0;
                end
                if (bit_idx != '0) begin
                    trial_next[bit_dn] = 1'b1;
                    bit_next           = bit_dn;
                    cnt_next           = SETTLE_LOAD;
                    state_next         = SETTLE;
                end else begin
                    state_next = DONE;
                end
            end

            DONE: begin
                if (cont_mode) begin
                    state_next = SAMPLE;
                    cnt_next   = SAMPLE_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                trial_next = '0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        eoc_d     = (state_next == DONE);
        cmp_clk_d = (state_next == COMPARE);
        busy_d    = (state_next != IDLE);

        // A single-shot request during a conversion is dropped but recorded;
        // a new overrun wins over a clear in the same cycle.
        if (cnvst && (state != IDLE) && !cont_mode) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        // Sampling switch closed only while idle or sampling.
        s_clk        = (state == IDLE) || (state == SAMPLE);
        s_clk_not    = ~s_clk;
        dac_code     = trial;
        dac_code_not = ~trial;
        sar          = sar_q;
        eoc          = eoc_q;
        busy         = busy_q;
        overrun      = overrun_q;
        cmp_clk      = cmp_clk_q;
    end

endmodule
